ace_line_port: RTL and testbench

Bus-side engine directly downstream of the cache controller. It turns the controller's read_req / write_req / invalid_req into ACE transactions on the interconnect:
- ReadShared line fill.
- WriteBack line eviction.
- MakeUnique invalidate.

It streams line words into and out of the cache datapath, and returns a single-cycle ace_ready when a transaction is complete.

---
 rtl/ace_line_port_if.sv | 38 +++
 rtl/ace_line_port.sv | 130 +++++++++++++
 tb/tb_ace_line_port.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ace_line_port_if.sv
// rtl/ace_line_port_if.sv - ACE AR/R/AW/W/B channel bundle between the line port and the interconnect
interface ace_line_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arsnoop;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  rack;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic                  wack;

    // R data goes straight into the cache datapath; the port only sequences the R flow control.
    modport master (
        output araddr, arsnoop, arvalid, rready, rack,
        output awaddr, awvalid, wdata, wlast, wvalid, bready, wack,
        input  arready, rlast, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  araddr, arsnoop, arvalid, rready, rack,
        input  awaddr, awvalid, wdata, wlast, wvalid, bready, wack,
        output arready, rdata, rlast, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/ace_line_port.sv
// rtl/ace_line_port.sv - ACE line engine: ReadShared fill, WriteBack eviction, MakeUnique invalidate
module ace_line_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          read_req,
    input  logic                          write_req,
    input  logic                          invalid_req,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic                          ace_ready,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [$clog2(LINE_WORDS)-1:0] wb_idx,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    ace_line_port_if.master               ace
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8 * LINE_WORDS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [3:0] SNOOP_READ_SHARED = 4'b0001;
    localparam logic [3:0] SNOOP_MAKE_UNIQUE = 4'b1100;

    typedef enum logic [2:0] {IDLE, AR_SEND, R_RECV, AW_SEND, W_SEND, B_WAIT, DONE} state_t;
    typedef enum logic [1:0] {KIND_FILL, KIND_INVAL, KIND_WB} kind_t;

    state_t                state, state_nxt;
    kind_t                 kind;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [3:0]            snoop;
    logic [IDX_W-1:0]      beat;
    logic                  accept;
    logic                  r_beat;
    logic                  w_beat;

    assign accept = (state == IDLE) && (write_req || invalid_req || read_req);
    assign r_beat = (state == R_RECV) && ace.rvalid;
    assign w_beat = (state == W_SEND) && ace.wready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ace_ready   = 1'b0;
        fill_we     = 1'b0;
        ace.arvalid = 1'b0;
        ace.rready  = 1'b0;
        ace.rack    = 1'b0;
        ace.awvalid = 1'b0;
        ace.wvalid  = 1'b0;
        ace.wlast   = 1'b0;
        ace.bready  = 1'b0;
        ace.wack    = 1'b0;
        case (state)
            IDLE: begin
                if (write_req)                    state_nxt = AW_SEND;
                else if (invalid_req || read_req) state_nxt = AR_SEND;
            end
            AR_SEND: begin
                ace.arvalid = 1'b1;
                if (ace.arready) state_nxt = R_RECV;
            end
            R_RECV: begin
                ace.rready = 1'b1;
                fill_we    = ace.rvalid && (kind == KIND_FILL);
                if (ace.rvalid && ace.rlast) state_nxt = DONE;
            end
            AW_SEND: begin
                ace.awvalid = 1'b1;
                if (ace.awready) state_nxt = W_SEND;
            end
            W_SEND: begin
                ace.wvalid = 1'b1;
                ace.wlast  = (beat == LAST_IDX);
                if (ace.wready && beat == LAST_IDX) state_nxt = B_WAIT;
            end
            B_WAIT: begin
                ace.bready = 1'b1;
                if (ace.bvalid) state_nxt = DONE;
            end
            DONE: begin
                ace_ready = 1'b1;
                ace.rack  = (kind != KIND_WB);
                ace.wack  = (kind == KIND_WB);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat count wraps naturally at LINE_WORDS, so a late rlast keeps overwriting from index 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind      <= KIND_FILL;
            line_addr <= '0;
            snoop     <= '0;
            beat      <= '0;
        end else if (accept) begin
            line_addr <= req_addr & LINE_MASK;
            beat      <= '0;
            if (write_req) begin
                kind  <= KIND_WB;
                snoop <= '0;
            end else if (invalid_req) begin
                kind  <= KIND_INVAL;
                snoop <= SNOOP_MAKE_UNIQUE;
            end else begin
                kind  <= KIND_FILL;
                snoop <= SNOOP_READ_SHARED;
            end
        end else if (r_beat || w_beat) begin
            beat <= beat + IDX_W'(1);
        end else if (state == DONE) begin
            beat <= '0;
        end
    end

    assign ace.araddr  = line_addr;
    assign ace.awaddr  = line_addr;
    assign ace.arsnoop = snoop;
    assign ace.wdata   = wb_data;
    assign fill_idx    = beat;
    assign wb_idx      = beat;
endmodule

// File: tb/tb_ace_line_port.sv
// tb/tb_ace_line_port.sv - randomized self-checking bench for ace_line_port against a transaction-level model
`timescale 1ns/1ps
module tb_ace_line_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = 2;
    localparam int LINE_BYTES = DW / 8 * LW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          read_req = 1'b0;
    logic          write_req = 1'b0;
    logic          invalid_req = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          ace_ready;
    logic          fill_we;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] wb_line [LW];
    int            checks = 0;
    int            errors = 0;

    ace_line_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ace_line_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req),
        .invalid_req(invalid_req), .req_addr(req_addr), .ace_ready(ace_ready),
        .fill_we(fill_we), .fill_idx(fill_idx), .wb_idx(wb_idx), .wb_data(wb_data),
        .ace(bus)
    );

    always #5 clk = ~clk;
    assign wb_data = wb_line[wb_idx];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        check(tag, {bus.arvalid, bus.rready, bus.rack, bus.awvalid, bus.wvalid, bus.wlast,
                    bus.bready, bus.wack, ace_ready, fill_we}, 10'd0);
    endtask

    task automatic do_fill(input bit inval, input logic [AW-1:0] addr, input int ar_stall,
                           input int nbeats, input bit stalls, input bit preissued);
        logic [DW-1:0] exp_line [LW];
        logic [DW-1:0] dp_line [LW];
        logic [AW-1:0] exp_addr;
        bit ar_done = 0;
        bit r_done = 0;
        int beat = 0, cyc = 0, rlast_cyc = 0, ar_wait = 0;
        exp_addr = addr - (addr % LINE_BYTES);
        for (int i = 0; i < LW; i++) begin exp_line[i] = '0; dp_line[i] = '0; end
        if (!preissued) begin
            @(negedge clk);
            req_addr = addr; read_req = !inval; invalid_req = inval;
        end
        while (!r_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            read_req = 0; invalid_req = 0; req_addr = $urandom;
            bus.arready = !ar_done && (ar_wait >= ar_stall) && (!stalls || $urandom_range(1, 0) != 0);
            bus.rvalid  = ar_done && (stalls ? ($urandom_range(1, 0) != 0) : (cyc >= 3));
            bus.rdata   = $urandom;
            bus.rlast   = (beat == nbeats - 1);
            #1;
            check("arvalid", bus.arvalid, !ar_done);
            if (bus.arvalid) begin
                check("araddr", bus.araddr, exp_addr);
                check("arsnoop", bus.arsnoop, inval ? 4'b1100 : 4'b0001);
            end
            check("rready", bus.rready, ar_done);
            check("fill_busy_quiet", {ace_ready, bus.awvalid, bus.wvalid, bus.bready}, 4'd0);
            check("fill_we", fill_we, bus.rvalid && ar_done && !inval);
            if (ar_done && bus.rvalid) begin
                if (!inval) check("fill_idx", fill_idx, beat % LW);
                exp_line[beat % LW] = bus.rdata;
                if (fill_we) dp_line[fill_idx] = bus.rdata;
                beat++;
                if (bus.rlast) begin r_done = 1; rlast_cyc = cyc; end
            end
            if (bus.arvalid && bus.arready) ar_done = 1;
            if (!ar_done) ar_wait++;
        end
        check("fill_done", r_done, 1'b1);
        if (!stalls && ar_stall == 0) check("rlast_cycle", rlast_cyc, 2 + nbeats);
        if (!inval) for (int i = 0; i < LW; i++) check("fill_line", dp_line[i], exp_line[i]);
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0; bus.arready = 0;
        #1;
        check("fill_ready_rack_wack", {ace_ready, bus.rack, bus.wack}, 3'b110);
        check("fill_done_quiet", {bus.arvalid, bus.rready, fill_we}, 3'd0);
        @(negedge clk);
        #1;
        chk_quiet("fill_back_idle");
    endtask

    task automatic do_wb(input logic [AW-1:0] addr, input int wmode, input bit hold_read,
                         input bit all_reqs, input logic [AW-1:0] next_addr);
        logic [AW-1:0] exp_addr;
        bit aw_done = 0, w_done = 0, b_done = 0;
        int beat = 0, cyc = 0;
        exp_addr = addr - (addr % LINE_BYTES);
        for (int i = 0; i < LW; i++) wb_line[i] = $urandom;
        @(negedge clk);
        req_addr = addr; write_req = 1; invalid_req = all_reqs; read_req = all_reqs || hold_read;
        while (!b_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            write_req = 0; invalid_req = 0; read_req = hold_read;
            req_addr = hold_read ? next_addr : $urandom;
            bus.awready = !aw_done && (wmode == 2 || $urandom_range(1, 0) != 0);
            bus.wready  = (wmode == 1) ? (cyc % 2 == 1) : (wmode == 2) ? 1'b1 : ($urandom_range(1, 0) != 0);
            bus.bvalid  = w_done && (wmode == 2 || $urandom_range(1, 0) != 0);
            #1;
            check("awvalid", bus.awvalid, !aw_done);
            if (bus.awvalid) check("awaddr", bus.awaddr, exp_addr);
            check("wvalid", bus.wvalid, aw_done && !w_done);
            check("bready", bus.bready, w_done);
            check("wb_busy_quiet", {bus.arvalid, bus.rready, ace_ready, fill_we}, 4'd0);
            if (bus.wvalid) begin
                check("wb_idx", wb_idx, beat);
                check("wdata", bus.wdata, wb_line[beat]);
                check("wlast", bus.wlast, beat == LW - 1);
                if (bus.wready) begin
                    beat++;
                    if (beat == LW) w_done = 1;
                end
            end else begin
                check("wlast_idle", bus.wlast, 1'b0);
            end
            if (bus.bready && bus.bvalid) b_done = 1;
            if (bus.awvalid && bus.awready) aw_done = 1;
        end
        check("wb_done", b_done, 1'b1);
        @(negedge clk);
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        #1;
        check("wb_ready_rack_wack", {ace_ready, bus.rack, bus.wack}, 3'b101);
        check("wb_done_quiet", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid}, 4'd0);
        @(negedge clk);
        #1;
        chk_quiet("wb_back_idle");
    endtask

    initial begin
        bus.arready = 0; bus.rdata = '0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        for (int i = 0; i < LW; i++) wb_line[i] = '0;

        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset_outputs");
        check("reset_araddr", bus.araddr, 32'd0);
        check("reset_awaddr", bus.awaddr, 32'd0);
        check("reset_snoop_idx", {bus.arsnoop, fill_idx, wb_idx}, 8'd0);
        @(negedge clk);
        reset = 1;

        do_fill(0, 32'h0000_1234, 0, LW, 0, 0);
        do_wb(32'h0000_8F3C, 1, 0, 0, 32'd0);
        do_fill(1, 32'h0040_0077, 3, 1, 0, 0);
        do_wb(32'h2000_0010, 2, 1, 1, 32'h3000_0024);
        do_fill(0, 32'h3000_0024, 0, LW, 0, 1);

        for (int i = 0; i < LW; i++) wb_line[i] = $urandom;
        @(negedge clk);
        req_addr = 32'h0000_ABCD; write_req = 1;
        @(negedge clk);
        write_req = 0; bus.awready = 1; bus.wready = 1;
        #1;
        check("rst_tc_awvalid", bus.awvalid, 1'b1);
        @(negedge clk);
        bus.awready = 0;
        #1;
        check("rst_tc_beat0", {bus.wvalid, wb_idx}, {1'b1, 2'd0});
        @(negedge clk);
        #1;
        check("rst_tc_beat1", {bus.wvalid, wb_idx}, {1'b1, 2'd1});
        #1;
        reset = 0;
        #1;
        chk_quiet("rst_async_valids");
        check("rst_async_araddr", bus.araddr, 32'd0);
        check("rst_async_awaddr", bus.awaddr, 32'd0);
        check("rst_async_idx", {bus.arsnoop, fill_idx, wb_idx}, 8'd0);
        bus.wready = 0;
        @(negedge clk);
        reset = 1;
        do_fill(0, 32'h0000_5678, 0, LW, 0, 0);

        for (int n = 0; n < 8; n++) begin
            int k;
            logic [AW-1:0] a;
            k = $urandom_range(2, 0);
            a = $urandom;
            if (k == 2) do_wb(a, 0, 0, 0, 32'd0);
            else        do_fill(k == 1, a, $urandom_range(2, 0), $urandom_range(6, 1), 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
